// File: rtl/fp_cons.sv
// Shared FP CSR constants: addresses, op encodings, rounding modes, flag layout.
package fp_cons;

  localparam logic [11:0] csr_fflags = 12'h001;
  localparam logic [11:0] csr_frm    = 12'h002;
  localparam logic [11:0] csr_fcsr   = 12'h003;

  localparam logic [1:0] csr_op_read  = 2'b00;
  localparam logic [1:0] csr_op_write = 2'b01;
  localparam logic [1:0] csr_op_set   = 2'b10;
  localparam logic [1:0] csr_op_clear = 2'b11;

  localparam logic [2:0] rm_rne = 3'b000;
  localparam logic [2:0] rm_rtz = 3'b001;
  localparam logic [2:0] rm_rdn = 3'b010;
  localparam logic [2:0] rm_rup = 3'b011;
  localparam logic [2:0] rm_rmm = 3'b100;
  localparam logic [2:0] rm_dyn = 3'b111;

  // Flag order matches the fflags bit layout, nv in bit 4 down to nx in bit 0.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fp_flags_t;

  // Read-modify-write result for a 5-bit field; read-only returns v unchanged.
  function automatic logic [4:0] csr_apply5(input logic [1:0] op,
                                            input logic [4:0] v,
                                            input logic [4:0] w);
    logic [4:0] r;
    r = v;
    case (op)
      csr_op_write: r = w;
      csr_op_set:   r = v | w;
      csr_op_clear: r = v & ~w;
      default:      r = v;
    endcase
    return r;
  endfunction

  // Same as csr_apply5 for the 3-bit frm field.
  function automatic logic [2:0] csr_apply3(input logic [1:0] op,
                                            input logic [2:0] v,
                                            input logic [2:0] w);
    logic [2:0] r;
    r = v;
    case (op)
      csr_op_write: r = w;
      csr_op_set:   r = v | w;
      csr_op_clear: r = v & ~w;
      default:      r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fp_rm_resolve.sv
// Resolves an instruction rm field against the registered frm.
module fp_rm_resolve
  import fp_cons::*;
#(
  parameter int RM_W = 3
) (
  input  logic [RM_W-1:0] inst_rm,
  input  logic [RM_W-1:0] frm,
  output logic [RM_W-1:0] rm_out,
  output logic            rm_illegal
);

  // Dynamic rm selects frm; the reserved encodings 101/110/111 are flagged.
  always_comb begin
    rm_out     = (inst_rm == rm_dyn) ? frm : inst_rm;
    rm_illegal = (rm_out == 3'b101) || (rm_out == 3'b110) || (rm_out == 3'b111);
  end

endmodule

// File: rtl/fp_csr_unit.sv
// FP CSR stage: fflags/frm state, CSR access, flag accumulation, rm resolution.
module fp_csr_unit
  import fp_cons::*;
#(
  parameter int XLEN    = 32,
  parameter int FLAGS_W = 5,
  parameter int RM_W    = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               csr_valid,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic               csr_rvalid,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               csr_illegal,
  input  logic               fpu_valid,
  input  logic [FLAGS_W-1:0] fpu_flags,
  input  logic [RM_W-1:0]    inst_rm,
  output logic [RM_W-1:0]    rm_out,
  output logic               rm_illegal,
  output logic               fs_dirty
);

  fp_flags_t          fflags_q;
  logic [RM_W-1:0]    frm_q;

  logic               hit_fflags, hit_frm, hit_fcsr, legal, wr;
  logic [FLAGS_W-1:0] fl_w, fl_new, fflags_next;
  logic [RM_W-1:0]    frm_w, frm_new, frm_next;
  logic [7:0]         view;
  logic               dirty_next;

  // Upper write-data bits never reach any field.
  logic unused_wdata;
  assign unused_wdata = ^csr_wdata[XLEN-1:8];

  // Decode the request and compute next-state for both fields.
  always_comb begin
    hit_fflags  = (csr_addr == csr_fflags);
    hit_frm     = (csr_addr == csr_frm);
    hit_fcsr    = (csr_addr == csr_fcsr);
    legal       = hit_fflags || hit_frm || hit_fcsr;
    wr          = csr_valid && legal && (csr_op != csr_op_read);

    fl_w        = csr_wdata[4:0];
    frm_w       = hit_fcsr ? csr_wdata[7:5] : csr_wdata[2:0];
    fl_new      = csr_apply5(csr_op, fflags_q, fl_w);
    frm_new     = csr_apply3(csr_op, frm_q, frm_w);

    // FPU flags are ORed in after the CSR result so none are lost.
    fflags_next = ((wr && (hit_fflags || hit_fcsr)) ? fl_new : fflags_q)
                | (fpu_valid ? fpu_flags : '0);
    frm_next    = (wr && (hit_frm || hit_fcsr)) ? frm_new : frm_q;

    // Any legal write attempt marks state dirty, even if the value is unchanged.
    dirty_next  = wr || (fpu_valid && (fpu_flags != '0));

    view = 8'h00;
    if (hit_fflags)    view = {3'b000, fflags_q};
    else if (hit_frm)  view = {5'b00000, frm_q};
    else if (hit_fcsr) view = {frm_q, fflags_q};
  end

  // Architectural state and the registered one-cycle response.
  always_ff @(posedge clock) begin
    if (reset) begin
      fflags_q    <= '0;
      frm_q       <= '0;
      csr_rvalid  <= 1'b0;
      csr_rdata   <= '0;
      csr_illegal <= 1'b0;
      fs_dirty    <= 1'b0;
    end else begin
      fflags_q    <= fp_flags_t'(fflags_next);
      frm_q       <= frm_next;
      csr_rvalid  <= csr_valid;
      csr_rdata   <= (csr_valid && legal) ? XLEN'(view) : '0;
      csr_illegal <= csr_valid && !legal;
      fs_dirty    <= dirty_next;
    end
  end

  fp_rm_resolve #(.RM_W(RM_W)) u_rm (
    .inst_rm    (inst_rm),
    .frm        (frm_q),
    .rm_out     (rm_out),
    .rm_illegal (rm_illegal)
  );

endmodule

// File: tb/tb_fp_csr_unit.sv
// Directed vector bench for fp_csr_unit.
module tb_fp_csr_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        csr_valid;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_rvalid;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        fpu_valid;
  logic [4:0]  fpu_flags;
  logic [2:0]  inst_rm;
  logic [2:0]  rm_out;
  logic        rm_illegal;
  logic        fs_dirty;

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  fp_csr_unit dut (
    .clock(clock), .reset(reset),
    .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rvalid(csr_rvalid), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .fpu_valid(fpu_valid), .fpu_flags(fpu_flags),
    .inst_rm(inst_rm), .rm_out(rm_out), .rm_illegal(rm_illegal),
    .fs_dirty(fs_dirty)
  );

  // Inputs applied for one cycle; rm expectations are pre-edge, the rest post-edge.
  typedef struct {
    logic        v;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wd;
    logic        fv;
    logic [4:0]  ff;
    logic [2:0]  irm;
    logic [2:0]  e_rm;
    logic        e_rmi;
    logic        e_rv;
    logic [31:0] e_rd;
    logic        e_ill;
    logic        e_dirty;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic idle();
    csr_valid = 1'b0; csr_op = 2'b00; csr_addr = 12'h000; csr_wdata = 32'h0;
    fpu_valid = 1'b0; fpu_flags = 5'h0; inst_rm = 3'b111;
  endtask

  initial begin
    //           v  op     addr    wdata         fv ff     irm     e_rm    rmi  rv  rdata         ill dirty
    vecs[0]  = '{1, 2'b00, 12'h003, 32'h0,        0, 5'h00, 3'b111, 3'b000, 0, 1, 32'h00, 0, 0};
    vecs[1]  = '{1, 2'b01, 12'h003, 32'hE3,       0, 5'h00, 3'b111, 3'b000, 0, 1, 32'h00, 0, 1};
    vecs[2]  = '{1, 2'b00, 12'h002, 32'h0,        0, 5'h00, 3'b111, 3'b111, 1, 1, 32'h07, 0, 0};
    vecs[3]  = '{1, 2'b00, 12'h001, 32'h0,        0, 5'h00, 3'b001, 3'b001, 0, 1, 32'h03, 0, 0};
    vecs[4]  = '{1, 2'b01, 12'h002, 32'h2,        0, 5'h00, 3'b111, 3'b111, 1, 1, 32'h07, 0, 1};
    vecs[5]  = '{0, 2'b00, 12'h000, 32'h0,        0, 5'h00, 3'b111, 3'b010, 0, 0, 32'h00, 0, 0};
    vecs[6]  = '{1, 2'b01, 12'h001, 32'h0,        0, 5'h00, 3'b000, 3'b000, 0, 1, 32'h03, 0, 1};
    vecs[7]  = '{1, 2'b11, 12'h001, 32'h1F,       1, 5'h01, 3'b111, 3'b010, 0, 1, 32'h00, 0, 1};
    vecs[8]  = '{1, 2'b00, 12'h001, 32'h0,        1, 5'h10, 3'b111, 3'b010, 0, 1, 32'h01, 0, 1};
    vecs[9]  = '{1, 2'b00, 12'h001, 32'h0,        0, 5'h00, 3'b111, 3'b010, 0, 1, 32'h11, 0, 0};
    vecs[10] = '{1, 2'b01, 12'h004, 32'hFFFF,     0, 5'h00, 3'b111, 3'b010, 0, 1, 32'h00, 1, 0};
    vecs[11] = '{1, 2'b00, 12'h003, 32'h0,        0, 5'h00, 3'b111, 3'b010, 0, 1, 32'h51, 0, 0};
    vecs[12] = '{1, 2'b10, 12'h001, 32'h0,        0, 5'h00, 3'b110, 3'b110, 1, 1, 32'h11, 0, 1};
    vecs[13] = '{0, 2'b00, 12'h000, 32'h0,        1, 5'h00, 3'b111, 3'b010, 0, 0, 32'h00, 0, 0};
    vecs[14] = '{1, 2'b01, 12'h003, 32'hFFFFFF80, 0, 5'h00, 3'b111, 3'b010, 0, 1, 32'h51, 0, 1};
    vecs[15] = '{1, 2'b00, 12'h003, 32'h0,        0, 5'h00, 3'b101, 3'b101, 1, 1, 32'h80, 0, 0};
    vecs[16] = '{1, 2'b11, 12'h002, 32'h4,        0, 5'h00, 3'b111, 3'b100, 0, 1, 32'h04, 0, 1};
    vecs[17] = '{1, 2'b00, 12'h002, 32'h0,        0, 5'h00, 3'b111, 3'b000, 0, 1, 32'h00, 0, 0};

    idle();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset_rvalid", 32'(csr_rvalid), 32'h0);
    chk("reset_rdata", csr_rdata, 32'h0);
    chk("reset_illegal", 32'(csr_illegal), 32'h0);
    chk("reset_dirty", 32'(fs_dirty), 32'h0);
    chk("reset_rm_dyn", 32'(rm_out), 32'h0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      csr_valid = vecs[i].v;  csr_op = vecs[i].op; csr_addr = vecs[i].addr;
      csr_wdata = vecs[i].wd; fpu_valid = vecs[i].fv; fpu_flags = vecs[i].ff;
      inst_rm = vecs[i].irm;
      #1;
      chk($sformatf("v%0d_rm_out", i), 32'(rm_out), 32'(vecs[i].e_rm));
      chk($sformatf("v%0d_rm_illegal", i), 32'(rm_illegal), 32'(vecs[i].e_rmi));
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_rvalid", i), 32'(csr_rvalid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) begin
        chk($sformatf("v%0d_rdata", i), csr_rdata, vecs[i].e_rd);
        chk($sformatf("v%0d_illegal", i), 32'(csr_illegal), 32'(vecs[i].e_ill));
      end
      chk($sformatf("v%0d_dirty", i), 32'(fs_dirty), 32'(vecs[i].e_dirty));
    end

    // Set fflags nonzero, then reset in the cycle a write of 0x1F is presented.
    @(negedge clock);
    idle();
    csr_valid = 1'b1; csr_op = 2'b01; csr_addr = 12'h001; csr_wdata = 32'h0A;
    @(negedge clock);
    csr_wdata = 32'h1F; reset = 1'b1; fpu_valid = 1'b1; fpu_flags = 5'h04;
    @(posedge clock);
    #1;
    chk("rst_rvalid", 32'(csr_rvalid), 32'h0);
    chk("rst_dirty", 32'(fs_dirty), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    idle();
    csr_valid = 1'b1; csr_op = 2'b00; csr_addr = 12'h003;
    @(posedge clock);
    #1;
    chk("rst_read_rvalid", 32'(csr_rvalid), 32'h1);
    chk("rst_read_fcsr", csr_rdata, 32'h0);
    @(negedge clock);
    idle();
    @(posedge clock);
    #1;
    chk("idle_rvalid", 32'(csr_rvalid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fp_csr_unit.md
Name: fp_csr_unit

Overview:
- Floating-point CSR stage sitting beside the FPU execute stage.
- Holds the architectural fflags and frm state, addressed at CSR 0x001 (fflags), 0x002 (frm) and 0x003 (fcsr).
- Serves CSR read/write/set/clear requests with a registered one-cycle response.
- Accumulates exception flags reported by completing FPU operations.
- Resolves each instruction's rm field (including dynamic, 3'b111) into the effective rounding mode for the FPU.

Parameters:
- XLEN, 32, width of CSR write/read data.
- FLAGS_W, 5, exception flag width (NV, DZ, OF, UF, NX, MSB first).
- RM_W, 3, rounding-mode field width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- csr_valid  in  1  CSR request strobe, one request per cycle.
- csr_op  in  2  00 read-only, 01 write, 10 set, 11 clear.
- csr_addr  in  12  CSR address.
- csr_wdata  in  XLEN  write/set/clear operand.
- csr_rvalid  out  1  response valid, exactly one cycle after csr_valid.
- csr_rdata  out  XLEN  old CSR value, zero-extended.
- csr_illegal  out  1  response flag: address not 0x001/0x002/0x003.
- fpu_valid  in  1  FPU operation retiring this cycle.
- fpu_flags  in  FLAGS_W  exception flags of the retiring operation.
- inst_rm  in  RM_W  rm field of the instruction in decode.
- rm_out  out  RM_W  effective rounding mode (combinational).
- rm_illegal  out  1  effective rounding mode is invalid (combinational).
- fs_dirty  out  1  one-cycle pulse after any fflags/frm change.

Behaviour:
- Reset values: fflags=0, frm=0, csr_rvalid=0, csr_rdata=0, csr_illegal=0, fs_dirty=0.
- Reset has priority over all same-cycle requests and flags. A request in flight when reset asserts gets no response.
- fcsr view = {24'b0, frm, fflags}. fflags view = {27'b0, fflags}. frm view = {29'b0, frm}.
- Response timing: csr_rvalid=1 in the cycle after csr_valid=1, else 0.
  - csr_rdata = view value before the update (pre-edge state), and excludes same-cycle fpu_flags.
  - If csr_illegal=1: csr_rdata=0 and no state change.
- Write data source:
  - fflags uses wdata[4:0].
  - frm uses wdata[2:0].
  - fcsr uses wdata[7:5] for frm and wdata[4:0] for fflags.
- New value per op, with v = selected field and w = selected wdata bits:
  - op 01: w.
  - op 10: v | w.
  - op 11: v & ~w.
  - op 00: no write.
- Ops 10/11 with w=0 leave the value unchanged, but still count as a write attempt for fs_dirty (see below).
- Next-state for fflags: fflags_next = (csr writes fflags ? csr_new : fflags) | (fpu_valid ? fpu_flags : 0). The OR is applied after the CSR result, so same-cycle FPU flags are never lost.
- Next-state for frm: updated only by CSR writes. Values 101/110/111 are stored as-is, not masked.
- fs_dirty=1 in the cycle after any of:
  - a legal CSR op!=00 targeting fflags, frm or fcsr;
  - fpu_valid=1 with fpu_flags!=0.
- Rounding-mode resolution (combinational):
  - rm_out = (inst_rm==3'b111) ? frm : inst_rm.
  - rm_illegal=1 iff rm_out ∈ {101, 110, 111}.
  - Uses the registered frm, so a CSR write to frm affects rm_out from the next cycle onward.
- No backpressure: csr_valid and fpu_valid are accepted every cycle.

Decomposition:
- Shared package fp_cons holds:
  - csr_fflags/csr_frm/csr_fcsr addresses (existing);
  - csr op encodings: csr_op_read=2'b00, csr_op_write=2'b01, csr_op_set=2'b10, csr_op_clear=2'b11;
  - rounding-mode constants: rm_rne=000, rm_rtz=001, rm_rdn=010, rm_rup=011, rm_rmm=100, rm_dyn=111;
  - a packed struct fp_flags_t {nv, dz, of, uf, nx}.
- One natural sub-module, fp_rm_resolve: purely combinational, inputs inst_rm and frm, outputs rm_out and rm_illegal.

Test Plan:
- Reset, then read 0x003 -> next cycle csr_rvalid=1, csr_rdata=0, csr_illegal=0.
- Write 0x003 wdata=0x000000E3 -> fs_dirty pulse next cycle; then read 0x002 -> rdata=0x7 and read 0x001 -> rdata=0x03.
  - With frm=111, inst_rm=111 -> rm_out=111, rm_illegal=1.
  - With inst_rm=001 -> rm_out=001, rm_illegal=0.
- Write frm=0x2, next cycle inst_rm=111 -> rm_out=010, rm_illegal=0.
  - In the same cycle as the write, rm_out still reflects the old frm.
- fflags=0x00; same cycle: CSR clear 0x001 wdata=0x1F and fpu_valid=1 with fpu_flags=0x01 -> fflags=0x01.
  - Response rdata=0x00 (old value).
  - Then fpu_flags=0x10 -> fflags=0x11.
- CSR read of 0x004 with wdata arbitrary and op 01 -> csr_illegal=1, rdata=0, state unchanged, no fs_dirty.
- Assert reset in the cycle a write of 0x001=0x1F is presented -> fflags stays 0, csr_rvalid=0 next cycle.
